// File: rtl/bpsk_demod.sv
// BPSK demodulator: recovers bits and LSB-first words from a 1-bit BPSK square wave
// by measuring run lengths; double-length runs (phase flips) align the bit slots.
module bpsk_demod #(
  parameter int CLOCK_IN      = 20_000_000,
  parameter int CLOCK_CARRIER = 64_000,
  parameter int DATA_WIDTH    = 8,
  parameter int CYCLE_COUNT   = 4
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  wave_in,
  input  logic                  bit_slip,
  output logic                  bit_out,
  output logic                  bit_valid,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  locked,
  output logic                  sync_err
);

  localparam int H   = CLOCK_IN / (CLOCK_CARRIER * 2);
  localparam int TOL = H / 4;
  localparam int S   = 2 * CYCLE_COUNT;
  localparam int SAT = 2 * H + TOL + 1;
  localparam int RW  = $clog2(SAT + 2);
  localparam int HW  = $clog2(S + 1);
  localparam int BW  = $clog2(DATA_WIDTH + 1);

  localparam logic [RW-1:0] SHORT_MIN = RW'(H - TOL);
  localparam logic [RW-1:0] SHORT_MAX = RW'(H + TOL);
  localparam logic [RW-1:0] LONG_MIN  = RW'(2 * H - TOL);
  localparam logic [RW-1:0] LONG_MAX  = RW'(2 * H + TOL);
  localparam logic [RW-1:0] RUN_SAT   = RW'(SAT);
  localparam logic [RW-1:0] RUN_PRE   = RW'(SAT - 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(S - 1);
  localparam logic [HW-1:0] HALF_ONE  = HW'(1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

  typedef enum logic {ST_HUNT, ST_LOCKED} state_t;

  state_t                state, state_n;
  logic                  s1, s2, s3;
  logic                  wave_edge;
  logic [RW-1:0]         run_cnt, run_len;
  logic [HW-1:0]         half_cnt, half_n;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] sh, sh_next;
  logic                  cur_bit, slip_pend;
  logic                  is_short, is_long, timeout;
  logic                  emit, err, take, clr_word, clr_cnt;

  assign wave_edge = s2 ^ s3;
  assign run_len   = run_cnt + RW'(1);
  assign is_short  = (run_len >= SHORT_MIN) && (run_len <= SHORT_MAX);
  assign is_long   = (run_len >= LONG_MIN) && (run_len <= LONG_MAX);
  // Fires only on the transition into saturation, never while parked there.
  assign timeout   = (run_cnt == RUN_PRE) && !wave_edge;
  assign sh_next   = {cur_bit, sh[DATA_WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!n_rst) state <= ST_HUNT;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    half_n   = half_cnt;
    emit     = 1'b0;
    err      = 1'b0;
    take     = 1'b0;
    clr_word = 1'b0;
    clr_cnt  = 1'b0;
    case (state)
      ST_HUNT: begin
        if (wave_edge && is_long) begin
          state_n = ST_LOCKED;
          half_n  = HALF_ONE;
          take    = 1'b1;
        end
      end
      default: begin
        if (wave_edge && is_short) begin
          if (half_cnt == '0) begin
            take   = 1'b1;
            half_n = HALF_ONE;
          end else if (half_cnt == HALF_LAST) begin
            emit   = 1'b1;
            half_n = '0;
          end else begin
            half_n = half_cnt + HW'(1);
          end
        end else if (wave_edge && is_long) begin
          take   = 1'b1;
          half_n = HALF_ONE;
          if (half_cnt == HALF_LAST) begin
            emit = 1'b1;
          end else begin
            // Phase flip in mid-slot: keep the lock but restart slot and word.
            err      = 1'b1;
            clr_word = 1'b1;
          end
        end else if (wave_edge || timeout) begin
          err     = 1'b1;
          state_n = ST_HUNT;
          half_n  = '0;
          clr_cnt = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      s1         <= wave_in;
      s2         <= wave_in;
      s3         <= wave_in;
      run_cnt    <= '0;
      half_cnt   <= '0;
      bit_cnt    <= '0;
      sh         <= '0;
      cur_bit    <= 1'b0;
      slip_pend  <= 1'b0;
      bit_out    <= 1'b0;
      bit_valid  <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      locked     <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      s1 <= wave_in;
      s2 <= s1;
      s3 <= s2;
      if (wave_edge)              run_cnt <= '0;
      else if (run_cnt != RUN_SAT) run_cnt <= run_cnt + RW'(1);
      half_cnt   <= half_n;
      if (take) cur_bit <= s3;
      locked     <= (state_n == ST_LOCKED);
      sync_err   <= err;
      bit_valid  <= emit;
      data_valid <= 1'b0;
      if (emit && slip_pend)                      slip_pend <= 1'b0;
      else if (bit_slip && state == ST_LOCKED)    slip_pend <= 1'b1;
      if (emit) begin
        bit_out <= cur_bit;
        sh      <= sh_next;
        if (!slip_pend) begin
          if (bit_cnt == BIT_LAST) begin
            data_out   <= sh_next;
            data_valid <= 1'b1;
            bit_cnt    <= '0;
          end else begin
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
      end
      if (clr_word) begin
        bit_cnt <= '0;
        sh      <= '0;
      end
      if (clr_cnt) bit_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_bpsk_demod.sv
// Testbench for bpsk_demod: drives a behavioural BPSK transmitter waveform and checks
// decoded bits, words, lock and error pulses against a slot-level reference model.
module tb_bpsk_demod;

  localparam int H = 156;
  localparam int S = 8;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic         wave_in = 1'b0;
  logic         bit_slip = 1'b0;
  logic         bit_out, bit_valid, data_valid, locked, sync_err;
  logic [W-1:0] data_out;

  int total = 0;
  int bad   = 0;

  bpsk_demod dut (
    .clk(clk), .n_rst(n_rst), .wave_in(wave_in), .bit_slip(bit_slip),
    .bit_out(bit_out), .bit_valid(bit_valid), .data_out(data_out),
    .data_valid(data_valid), .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit           got_bits[$];
  logic [W-1:0] got_words[$];
  int           err_cnt = 0, lock_cnt = 0, orphan = 0, err_cyc = 0;

  always @(negedge clk) begin
    if (bit_valid === 1'b1) got_bits.push_back(bit_out);
    if (data_valid === 1'b1) begin
      got_words.push_back(data_out);
      if (bit_valid !== 1'b1) orphan <= orphan + 1;
    end
    if (sync_err === 1'b1) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
    if (locked === 1'b1) lock_cnt <= lock_cnt + 1;
  end

  // Stimulus description: one entry per transmitted bit slot.
  bit   tx[64];
  bit   slp_a[64], slp_b[64];
  int   brk_t[64];
  int   n;
  int   edge_cyc;
  logic g_locked;
  int   g_err;
  logic [12:0] r_out;

  bit           exp_bits[$];
  logic [W-1:0] exp_words[$];
  bit           hist[$];
  int           exp_err, m_cnt;
  bit           m_pend;
  int           err_base, lock_base, orph_base;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input int k);
    repeat (k) tick();
  endtask

  task automatic set_wave(input logic v);
    if (v !== wave_in) edge_cyc = cyc;
    wave_in = v;
  endtask

  task automatic clear_stim();
    for (int i = 0; i < 64; i++) begin
      tx[i] = 1'b0; slp_a[i] = 1'b0; slp_b[i] = 1'b0; brk_t[i] = 0;
    end
  endtask

  task automatic start_run();
    n_rst = 1'b0;
    set_wave(1'b0);
    hold(3);
    n_rst = 1'b1;
    hold(400);
    got_bits.delete();
    got_words.delete();
    err_base  = err_cnt;
    lock_base = lock_cnt;
    orph_base = orphan;
  endtask

  // Transmitter: each bit is S half-periods of H clocks, first half at the bit level.
  task automatic send();
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < S; k++) begin
        logic lv;
        lv = tx[i] ^ k[0];
        set_wave(lv);
        if (k == 3 && slp_a[i]) begin
          bit_slip = 1'b1; tick(); bit_slip = 1'b0; hold(H - 1);
        end else if (k == 3 && brk_t[i] == 1) begin
          hold(50); set_wave(~lv); hold(10); set_wave(lv); hold(20);
          g_locked = locked;
          g_err    = err_cnt;
          hold(H - 80);
        end else if (k == 3 && brk_t[i] == 2) begin
          hold(50);
          n_rst = 1'b0;
          tick();
          r_out = {bit_out, bit_valid, data_out, data_valid, locked, sync_err};
          n_rst = 1'b1;
          hold(H - 51);
        end else if (k == 5 && slp_b[i]) begin
          bit_slip = 1'b1; tick(); bit_slip = 1'b0; hold(H - 1);
        end else begin
          hold(H);
        end
      end
    end
  endtask

  task automatic m_emit(input bit v);
    logic [W-1:0] w;
    hist.push_back(v);
    exp_bits.push_back(v);
    if (m_pend) m_pend = 1'b0;
    else if (m_cnt == W - 1) begin
      for (int k = 0; k < W; k++) w[k] = hist[hist.size() - W + k];
      exp_words.push_back(w);
      m_cnt = 0;
    end else m_cnt++;
  endtask

  // Slot-level model: a slot boundary with a level change is a LONG run (locks or
  // keeps lock); every slot boundary while locked delivers the previous slot's bit.
  // The last slot never gets a closing edge, so it is never delivered.
  task automatic model_run();
    bit lk;
    lk = 1'b0; m_cnt = 0; m_pend = 1'b0; exp_err = 0;
    exp_bits.delete(); exp_words.delete(); hist.delete();
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        if (lk) m_emit(tx[i-1]);
        else if (tx[i] != tx[i-1]) lk = 1'b1;
      end
      if (lk && (slp_a[i] || slp_b[i])) m_pend = 1'b1;
      if (brk_t[i] == 1 && lk) begin exp_err++; lk = 1'b0; m_cnt = 0; end
      if (brk_t[i] == 2) begin lk = 1'b0; m_cnt = 0; m_pend = 1'b0; end
    end
    if (lk) exp_err++;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    wave_in = 1'($urandom);
    hold(3);
    total++; if (bit_out !== 1'b0) begin bad++; $display("FAIL rst_bit_out: got %b want 0", bit_out); end
    total++; if (bit_valid !== 1'b0) begin bad++; $display("FAIL rst_bit_valid: got %b want 0", bit_valid); end
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL rst_data_out: got %h want 00", data_out); end
    total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL rst_data_valid: got %b want 0", data_valid); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL rst_locked: got %b want 0", locked); end
    total++; if (sync_err !== 1'b0) begin bad++; $display("FAIL rst_sync_err: got %b want 0", sync_err); end
    n_rst = 1'b1;
    hold(20);
    total++; if (locked !== 1'b0 || bit_valid !== 1'b0 || sync_err !== 1'b0) begin
      bad++; $display("FAIL rst_idle: got locked=%b bv=%b err=%b want 0/0/0", locked, bit_valid, sync_err);
    end
  endtask

  task automatic test_random();
    clear_stim();
    n = 14;
    for (int i = 0; i < n; i++) tx[i] = 1'($urandom);
    tx[0] = 1'b0; tx[1] = 1'b1; tx[n-1] = 1'b1;
    model_run();
    start_run();
    send();
    hold(500);
    total++; if (got_bits.size() != exp_bits.size()) begin
      bad++; $display("FAIL rand_bit_count: got %0d want %0d", got_bits.size(), exp_bits.size());
    end
    for (int k = 0; k < got_bits.size() && k < exp_bits.size(); k++) begin
      total++; if (got_bits[k] !== exp_bits[k]) begin
        bad++; $display("FAIL rand_bit[%0d]: got %b want %b", k, got_bits[k], exp_bits[k]);
      end
    end
    total++; if (got_words.size() != exp_words.size()) begin
      bad++; $display("FAIL rand_word_count: got %0d want %0d", got_words.size(), exp_words.size());
    end
    for (int k = 0; k < got_words.size() && k < exp_words.size(); k++) begin
      total++; if (got_words[k] !== exp_words[k]) begin
        bad++; $display("FAIL rand_word[%0d]: got %h want %h", k, got_words[k], exp_words[k]);
      end
    end
    total++; if (err_cnt - err_base != exp_err) begin
      bad++; $display("FAIL rand_sync_err: got %0d want %0d", err_cnt - err_base, exp_err);
    end
    total++; if (lock_cnt == lock_base) begin bad++; $display("FAIL rand_lock_seen: got 0 want >0 locked cycles"); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL rand_final_locked: got %b want 0", locked); end
    total++; if (orphan != orph_base) begin bad++; $display("FAIL rand_dv_alone: got %0d want 0", orphan - orph_base); end
    total++; if (err_cyc - edge_cyc < 350 || err_cyc - edge_cyc > 360) begin
      bad++; $display("FAIL rand_timeout_delay: got %0d want 350..360", err_cyc - edge_cyc);
    end
  endtask

  task automatic test_zero();
    clear_stim();
    n = 16;
    start_run();
    send();
    hold(100);
    total++; if (got_bits.size() != 0) begin bad++; $display("FAIL zero_bits: got %0d want 0", got_bits.size()); end
    total++; if (err_cnt != err_base) begin bad++; $display("FAIL zero_sync_err: got %0d want 0", err_cnt - err_base); end
    total++; if (lock_cnt != lock_base) begin bad++; $display("FAIL zero_locked: got %0d want 0 locked cycles", lock_cnt - lock_base); end
  endtask

  task automatic test_slip();
    logic [W-1:0] pat;
    pat = 8'hA5;
    clear_stim();
    n = 20;
    for (int i = 0; i < n; i++) tx[i] = pat[i % W];
    slp_a[0] = 1'b1;
    slp_a[10] = 1'b1; slp_b[10] = 1'b1;
    model_run();
    start_run();
    send();
    hold(500);
    total++; if (got_bits.size() != exp_bits.size()) begin
      bad++; $display("FAIL slip_bit_count: got %0d want %0d", got_bits.size(), exp_bits.size());
    end
    for (int k = 0; k < got_bits.size() && k < exp_bits.size(); k++) begin
      total++; if (got_bits[k] !== exp_bits[k]) begin
        bad++; $display("FAIL slip_bit[%0d]: got %b want %b", k, got_bits[k], exp_bits[k]);
      end
    end
    total++; if (got_words.size() != exp_words.size()) begin
      bad++; $display("FAIL slip_word_count: got %0d want %0d", got_words.size(), exp_words.size());
    end
    for (int k = 0; k < got_words.size() && k < exp_words.size(); k++) begin
      total++; if (got_words[k] !== exp_words[k]) begin
        bad++; $display("FAIL slip_word[%0d]: got %h want %h", k, got_words[k], exp_words[k]);
      end
    end
    total++; if (err_cnt - err_base != exp_err) begin
      bad++; $display("FAIL slip_sync_err: got %0d want %0d", err_cnt - err_base, exp_err);
    end
  endtask

  task automatic test_break();
    clear_stim();
    n = 14;
    for (int i = 0; i < n; i++) tx[i] = 1'($urandom);
    tx[0] = 1'b0; tx[1] = 1'b1;
    tx[5] = ~tx[4]; tx[11] = ~tx[10]; tx[n-1] = 1'b1;
    brk_t[4] = 1; brk_t[10] = 2;
    model_run();
    start_run();
    send();
    hold(500);
    total++; if (g_locked !== 1'b0) begin bad++; $display("FAIL glitch_locked: got %b want 0", g_locked); end
    total++; if (g_err - err_base != 1) begin bad++; $display("FAIL glitch_sync_err: got %0d want 1", g_err - err_base); end
    total++; if (r_out !== 13'h0) begin bad++; $display("FAIL midrst_outputs: got %h want 0000", r_out); end
    total++; if (got_bits.size() != exp_bits.size()) begin
      bad++; $display("FAIL brk_bit_count: got %0d want %0d", got_bits.size(), exp_bits.size());
    end
    for (int k = 0; k < got_bits.size() && k < exp_bits.size(); k++) begin
      total++; if (got_bits[k] !== exp_bits[k]) begin
        bad++; $display("FAIL brk_bit[%0d]: got %b want %b", k, got_bits[k], exp_bits[k]);
      end
    end
    total++; if (got_words.size() != exp_words.size()) begin
      bad++; $display("FAIL brk_word_count: got %0d want %0d", got_words.size(), exp_words.size());
    end
    total++; if (err_cnt - err_base != exp_err) begin
      bad++; $display("FAIL brk_sync_err: got %0d want %0d", err_cnt - err_base, exp_err);
    end
  endtask

  initial begin
    test_reset();
    test_random();
    test_zero();
    test_slip();
    test_break();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bpsk_demod.md
Name: bpsk_demod

Overview:
- Recovers bits and words from the 1-bit BPSK square wave produced by the team's BPSK transmitter.
- Demodulation uses run-length measurement only; no local carrier.
- Phase flips appear on the wire as double-length runs. These align bit slots; the bit value is the wave level in the first half-period of each slot.
- Words are assembled LSB-first. Word boundary is adjusted by a bit_slip request.

Parameters:
- CLOCK_IN, 20_000_000: system clock frequency in Hz.
- CLOCK_CARRIER, 64_000: carrier frequency in Hz.
- DATA_WIDTH, 8: bits per word.
- CYCLE_COUNT, 4: carrier cycles per bit.
- H (derived): CLOCK_IN/(CLOCK_CARRIER*2), integer division; half-period in clocks; 156 at defaults.
- TOL, H/4: run-length tolerance in clocks; 39 at defaults.
- S (derived): 2*CYCLE_COUNT; half-periods per bit slot.

Ports:
- clk, in, 1: clock.
- n_rst, in, 1: reset, synchronous, active-low.
- wave_in, in, 1: asynchronous BPSK wave.
- bit_slip, in, 1: one-cycle pulse; delays the word boundary by one bit.
- bit_out, out, 1: decoded bit.
- bit_valid, out, 1: one-cycle strobe for bit_out.
- data_out, out, DATA_WIDTH: assembled word.
- data_valid, out, 1: one-cycle strobe for data_out.
- locked, out, 1: slot alignment held.
- sync_err, out, 1: one-cycle pulse on loss of alignment.

Behaviour:
- Reset (n_rst=0 at a clk edge):
  - All outputs go to 0; state goes to HUNT.
  - run_cnt, half_cnt, bit_cnt, shift register, cur_bit and slip_pend are cleared.
  - Synchronizer flops are loaded with wave_in.
  - Reset mid-operation discards any partial word.
- Input path:
  - Two-flop synchronizer s1->s2, then one delay flop s3.
  - edge = s2^s3. The level of the run that just ended is s3.
- Run length:
  - run_cnt increments every clock and saturates at 2H+TOL+1.
  - On an edge, run length L = run_cnt + 1, then run_cnt <= 0.
  - SHORT: H-TOL <= L <= H+TOL.
  - LONG: 2H-TOL <= L <= 2H+TOL.
  - Any other length is BAD.
- HUNT state:
  - SHORT and BAD runs are ignored; sync_err is not raised.
  - On a LONG run: go to LOCKED, half_cnt <= 1, cur_bit <= s3, locked <= 1. No bit is emitted.
- LOCKED state, on each edge:
  - SHORT with half_cnt==0: cur_bit <= s3, half_cnt <= 1.
  - SHORT with 0<half_cnt<S-1: half_cnt += 1.
  - SHORT with half_cnt==S-1: emit cur_bit, half_cnt <= 0.
  - LONG with half_cnt==S-1: emit cur_bit, cur_bit <= s3, half_cnt <= 1.
  - LONG at any other half_cnt: realign. Pulse sync_err, set half_cnt <= 1 and cur_bit <= s3, emit nothing, clear bit_cnt and shift register. State stays LOCKED.
  - BAD run: pulse sync_err, go to HUNT, locked <= 0, clear half_cnt and bit_cnt.
- LOCKED state, timeout: run_cnt reaching 2H+TOL+1 with no edge has the same effect as a BAD run. It fires once; the saturated counter does not re-fire.
- Emit:
  - Registered, on the clock after the edge cycle: bit_out <= cur_bit, bit_valid = 1.
  - sh <= {cur_bit, sh[W-1:1]}.
  - If slip_pend: clear slip_pend and leave bit_cnt unchanged.
  - Else if bit_cnt==W-1: data_out <= {cur_bit, sh[W-1:1]}, data_valid = 1 in the same cycle as bit_valid, bit_cnt <= 0.
  - Else bit_cnt += 1.
- bit_slip:
  - Sets slip_pend only while locked; ignored in HUNT.
  - Further pulses while slip_pend is set coalesce into a single slip.
- Latency: from an edge at s2 to bit_valid is 1 clock. Total latency from wave_in is 3–4 clocks.
- Lock requires at least one data transition, i.e. one LONG run. A constant word never locks.
- Each emitted bit occupies S*H clocks (1248 at defaults); a word occupies W*S*H clocks (9984 at defaults).

Test Plan:
- Loopback with the team's BPSK transmitter at defaults, data_in=8'hA5, resets released together -> locked=1 after the first LONG run. After at most 7 bit_slip pulses (one per word), data_out=8'hA5 with data_valid every 9984 clocks. No sync_err.
- Loopback with data_in=8'h00 for 20000 clocks -> locked=0, no bit_valid, no sync_err.
- Locked on 8'hA5, then bit_slip pulsed once -> next data_out is ROR1 of the previous word: 8'hA5 becomes 8'hD2. Two pulses within one bit period give only one slip.
- Locked, then a 10-clock pulse injected into wave_in -> sync_err pulses once, locked=0. Relock at the next LONG run, and bits resume correct.
- Locked, then wave_in held low for 400 clocks -> sync_err once 352 clocks after the last edge (run_cnt saturation plus register delay), locked=0. No further sync_err while held.
- n_rst low for 1 cycle mid-word -> on the next cycle all outputs are 0 and locked=0. The partial word is never output.
